// File: rtl/axis_checker_pkg.sv
// Shared types and helpers for the AXI4-Stream pattern checker.
package axis_checker_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} stateT;

  // Galois LFSR for x^16+x^14+x^13+x^11+1, right-shifting form.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Increment v, holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] satInc(input logic [63:0] v, input int unsigned width);
    logic [63:0] maxVal;
    maxVal = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (v == maxVal) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/axis_sat_counter.sv
// Saturating event counter; a synchronous clear zeroes it before the same
// cycle's increment is applied, so clear+inc yields 1.
module axis_sat_counter
  import axis_checker_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] value
);

  logic [CNT_WIDTH-1:0] base;
  logic [CNT_WIDTH-1:0] nextVal;

  // Clear first, then apply the saturating increment.
  always_comb begin
    base    = clr ? '0 : value;
    nextVal = inc ? CNT_WIDTH'(satInc(64'(base), CNT_WIDTH)) : base;
  end

  // Counter register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) value <= '0;
    else          value <= nextVal;
  end

endmodule

// File: rtl/axis_pattern_checker.sv
// AXI4-Stream sink that checks fixed-length packets carrying SEED, SEED+1, ...
// Optional macro AXIS_PATTERN_CHECKER_BP_EN adds LFSR-driven backpressure on tready.
module axis_pattern_checker
  import axis_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PKT_LEN    = 8,
  parameter int unsigned SEED       = 1,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH-1:0]    word_count,
  output logic [CNT_WIDTH-1:0]    data_err_count,
  output logic [CNT_WIDTH-1:0]    len_err_count,
  output logic                    err_flag,
  output logic [DATA_WIDTH-1:0]   first_err_data,
  output logic [7:0]              first_err_idx,
  output logic                    pkt_done,
  output logic                    pkt_ok
);

  localparam logic [DATA_WIDTH-1:0] SeedVal = DATA_WIDTH'(SEED);
  localparam logic [7:0]            LastIdx = 8'(PKT_LEN - 1);

  stateT                 state;
  logic [7:0]            beatIdx;
  logic [DATA_WIDTH-1:0] expected;
  logic                  pktErr;
  logic                  treadyQ;
  logic                  errFlagQ;
  logic [DATA_WIDTH-1:0] firstErrDataQ;
  logic [7:0]            firstErrIdxQ;
  logic                  pktDoneQ;
  logic                  pktOkQ;
  logic                  readyNext;

  logic accept, checking, atLast, dataErr, lenErr, beatErr, pktEnd;
  logic unusedStrb;

  // tstrb is informational only.
  assign unusedStrb = ^s_axis_tstrb;

`ifdef AXIS_PATTERN_CHECKER_BP_EN
  logic [15:0] lfsr;

  // Free-running LFSR; its low bit gates ready to stall the source.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) lfsr <= LfsrSeed;
    else          lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LfsrTaps) : (lfsr >> 1);
  end
  assign readyNext = enable & lfsr[0];
`else
  assign readyNext = enable;
`endif

  // Per-beat decode; DRAIN beats are counted but never checked.
  always_comb begin
    accept   = s_axis_tvalid & treadyQ;
    checking = (state != DRAIN);
    atLast   = (beatIdx == LastIdx);
    dataErr  = accept & checking & (s_axis_tdata != expected);
    lenErr   = accept & checking & (s_axis_tlast != atLast);
    beatErr  = dataErr | lenErr;
    pktEnd   = accept & s_axis_tlast;
  end

  // Packet FSM with registered ready, status pulses and first-error capture.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      beatIdx       <= '0;
      expected      <= SeedVal;
      pktErr        <= 1'b0;
      treadyQ       <= 1'b0;
      errFlagQ      <= 1'b0;
      firstErrDataQ <= '0;
      firstErrIdxQ  <= '0;
      pktDoneQ      <= 1'b0;
      pktOkQ        <= 1'b0;
    end else begin
      treadyQ  <= readyNext;
      pktDoneQ <= pktEnd;
      pktOkQ   <= pktEnd & checking & ~pktErr & ~beatErr;
      errFlagQ <= (errFlagQ & ~clear) | beatErr;
      // A clear in the same cycle re-arms capture for this beat.
      if (dataErr && (clear || !errFlagQ)) begin
        firstErrDataQ <= s_axis_tdata;
        firstErrIdxQ  <= beatIdx;
      end
      if (accept) begin
        case (state)
          IDLE, ACTIVE: begin
            if (s_axis_tlast) begin
              state    <= IDLE;
              beatIdx  <= '0;
              expected <= SeedVal;
              pktErr   <= 1'b0;
            end else if (atLast) begin
              state    <= DRAIN;
              beatIdx  <= '0;
              expected <= SeedVal;
              pktErr   <= 1'b1;
            end else begin
              state    <= ACTIVE;
              beatIdx  <= beatIdx + 8'd1;
              expected <= expected + DATA_WIDTH'(1);
              pktErr   <= pktErr | dataErr;
            end
          end
          DRAIN: begin
            if (s_axis_tlast) begin
              state  <= IDLE;
              pktErr <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign s_axis_tready  = treadyQ;
  assign err_flag       = errFlagQ;
  assign first_err_data = firstErrDataQ;
  assign first_err_idx  = firstErrIdxQ;
  assign pkt_done       = pktDoneQ;
  assign pkt_ok         = pktOkQ;

  axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uPktCnt (
    .ACLK(ACLK), .ARESETN(ARESETN), .inc(pktEnd), .clr(clear), .value(pkt_count)
  );
  axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uWordCnt (
    .ACLK(ACLK), .ARESETN(ARESETN), .inc(accept), .clr(clear), .value(word_count)
  );
  axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uDataErrCnt (
    .ACLK(ACLK), .ARESETN(ARESETN), .inc(dataErr), .clr(clear), .value(data_err_count)
  );
  axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) uLenErrCnt (
    .ACLK(ACLK), .ARESETN(ARESETN), .inc(lenErr), .clr(clear), .value(len_err_count)
  );

endmodule

// File: tb/tb_axis_pattern_checker.sv
// Self-checking bench for axis_pattern_checker: directed table, hand-written
// corner sequences and randomized packets against a packet-level model.
// Build with AXIS_PATTERN_CHECKER_BP_EN defined to add the backpressure run.
module tb_axis_pattern_checker;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned PKT_LEN    = 8;
  localparam int unsigned SEED       = 1;
  localparam int unsigned CNT_WIDTH  = 32;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tstrb = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] pkt_count, word_count, data_err_count, len_err_count;
  logic        err_flag;
  logic [31:0] first_err_data;
  logic [7:0]  first_err_idx;
  logic        pkt_done, pkt_ok;

  axis_pattern_checker #(
    .DATA_WIDTH(DATA_WIDTH), .PKT_LEN(PKT_LEN), .SEED(SEED), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN), .enable(enable), .clear(clear),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .pkt_count(pkt_count), .word_count(word_count), .data_err_count(data_err_count),
    .len_err_count(len_err_count), .err_flag(err_flag), .first_err_data(first_err_data),
    .first_err_idx(first_err_idx), .pkt_done(pkt_done), .pkt_ok(pkt_ok)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  initial assert (PKT_LEN >= 2) else $fatal(1, "PKT_LEN must be at least 2");

  int tests = 0;
  int fails = 0;
  int totalCycles = 0;
  int lowCycles = 0;
  logic lastOk = 1'b0;

  // Reference model state: counters plus the beats seen in the current packet.
  int unsigned mPkt, mWord, mDataErr, mLenErr;
  bit          mErr, mBad;
  logic [31:0] mFirstData;
  int          mFirstIdx;
  int          mBeats;
  bit          expDone, expOk;

  task automatic chk(input string what, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", what, got, want);
    end
  endtask

  function automatic int unsigned bump(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic modelReset();
    mPkt = 0; mWord = 0; mDataErr = 0; mLenErr = 0;
    mErr = 0; mBad = 0; mFirstData = '0; mFirstIdx = 0; mBeats = 0;
    expDone = 0; expOk = 0;
  endtask

  task automatic modelClear();
    mPkt = 0; mWord = 0; mDataErr = 0; mLenErr = 0; mErr = 0;
  endtask

  // Beat i of a packet must be SEED+i; the packet must end exactly at PKT_LEN-1.
  task automatic modelBeat(input logic [31:0] d, input logic l);
    int idx;
    bit de, le;
    idx = mBeats;
    de = (idx < PKT_LEN) && (d != 32'(SEED + idx));
    le = (idx < PKT_LEN) && (l != (idx == PKT_LEN - 1));
    mWord = bump(mWord);
    if (de) mDataErr = bump(mDataErr);
    if (le) mLenErr = bump(mLenErr);
    if (de && !mErr) begin
      mFirstData = d;
      mFirstIdx  = idx;
    end
    if (de || le) mErr = 1;
    mBad = mBad | de | le;
    if (l) begin
      mPkt    = bump(mPkt);
      expDone = 1;
      expOk   = !mBad;
      mBeats  = 0;
      mBad    = 0;
    end else begin
      mBeats++;
    end
  endtask

  // One clock: inputs are already set; tready is stable between edges.
  task automatic cycle();
    logic acc, l, c;
    logic [31:0] d;
    acc = s_axis_tvalid && s_axis_tready;
    d = s_axis_tdata; l = s_axis_tlast; c = clear;
    totalCycles++;
    if (!s_axis_tready) lowCycles++;
    @(posedge tb_ACLK);
    expDone = 0;
    if (c) modelClear();
    if (acc) modelBeat(d, l);
    @(negedge tb_ACLK);
    chk("pkt_done", {63'd0, pkt_done}, {63'd0, expDone});
    if (expDone) begin
      chk("pkt_ok", {63'd0, pkt_ok}, {63'd0, expOk});
      lastOk = pkt_ok;
    end
  endtask

  task automatic sendBeat(input logic [31:0] d, input logic l, input bit withClr);
    bit done;
    int n;
    done = 0; n = 0;
    s_axis_tvalid = 1; s_axis_tdata = d; s_axis_tlast = l;
    s_axis_tstrb = 4'($urandom); clear = withClr;
    while (!done) begin
      done = s_axis_tready;
      cycle();
      clear = 0;
      n++;
      if (!done && n >= 200) begin
        tests++; fails++;
        $display("FAIL accept_timeout: beat not accepted after %0d cycles", n);
        done = 1;
      end
    end
    s_axis_tvalid = 0;
  endtask

  task automatic sendPacket(input int len, input int badIdx, input logic [31:0] badVal);
    for (int i = 0; i < len; i++)
      sendBeat((i == badIdx) ? badVal : 32'(SEED + i), (i == len - 1), 0);
  endtask

  task automatic pulseClear();
    s_axis_tvalid = 0; clear = 1;
    cycle();
    clear = 0;
  endtask

  task automatic checkCounters(input string tag);
    chk({tag, " pkt_count"}, 64'(pkt_count), 64'(mPkt));
    chk({tag, " word_count"}, 64'(word_count), 64'(mWord));
    chk({tag, " data_err_count"}, 64'(data_err_count), 64'(mDataErr));
    chk({tag, " len_err_count"}, 64'(len_err_count), 64'(mLenErr));
    chk({tag, " err_flag"}, {63'd0, err_flag}, {63'd0, mErr});
    chk({tag, " first_err_data"}, 64'(first_err_data), 64'(mFirstData));
    chk({tag, " first_err_idx"}, 64'(first_err_idx), 64'(mFirstIdx));
  endtask

  task automatic doReset();
    @(negedge tb_ACLK);
    tb_ARESETN = 0; s_axis_tvalid = 0; clear = 0;
    modelReset();
    @(negedge tb_ACLK);
    checkCounters("reset");
    chk("reset tready", {63'd0, s_axis_tready}, 64'd0);
    chk("reset pkt_done", {63'd0, pkt_done}, 64'd0);
    chk("reset pkt_ok", {63'd0, pkt_ok}, 64'd0);
    @(negedge tb_ACLK);
    tb_ARESETN = 1;
  endtask

  typedef struct {
    string       name;
    bit          clrFirst;
    int          len;
    int          badIdx;
    logic [31:0] badVal;
    int          ePkt, eWord, eData, eLen;
    bit          eFlag;
    logic [31:0] eFirstData;
    int          eFirstIdx;
    bit          eOk;
  } vecT;

  vecT vecs[7];

  initial begin
    vecs[0] = '{"good", 1, 8, -1, 0, 1, 8, 0, 0, 0, 32'h0, 0, 1};
    vecs[1] = '{"bad3", 1, 8, 3, 32'hDEAD0000, 1, 8, 1, 0, 1, 32'hDEAD0000, 3, 0};
    vecs[2] = '{"bad5", 0, 8, 5, 32'hBEEF0000, 2, 16, 2, 0, 1, 32'hDEAD0000, 3, 0};
    vecs[3] = '{"short", 1, 5, -1, 0, 1, 5, 0, 1, 1, 32'hDEAD0000, 3, 0};
    vecs[4] = '{"after_short", 0, 8, -1, 0, 2, 13, 0, 1, 1, 32'hDEAD0000, 3, 1};
    vecs[5] = '{"long", 1, 10, -1, 0, 1, 10, 0, 1, 1, 32'hDEAD0000, 3, 0};
    vecs[6] = '{"after_long", 0, 8, -1, 0, 2, 18, 0, 1, 1, 32'hDEAD0000, 3, 1};

    enable = 1;
    doReset();

    // Directed table.
    foreach (vecs[i]) begin
      if (vecs[i].clrFirst) pulseClear();
      sendPacket(vecs[i].len, vecs[i].badIdx, vecs[i].badVal);
      cycle();
      chk({vecs[i].name, " pkt_count"}, 64'(pkt_count), 64'(vecs[i].ePkt));
      chk({vecs[i].name, " word_count"}, 64'(word_count), 64'(vecs[i].eWord));
      chk({vecs[i].name, " data_err"}, 64'(data_err_count), 64'(vecs[i].eData));
      chk({vecs[i].name, " len_err"}, 64'(len_err_count), 64'(vecs[i].eLen));
      chk({vecs[i].name, " err_flag"}, {63'd0, err_flag}, {63'd0, vecs[i].eFlag});
      chk({vecs[i].name, " first_data"}, 64'(first_err_data), 64'(vecs[i].eFirstData));
      chk({vecs[i].name, " first_idx"}, 64'(first_err_idx), 64'(vecs[i].eFirstIdx));
      chk({vecs[i].name, " last_pkt_ok"}, {63'd0, lastOk}, {63'd0, vecs[i].eOk});
      checkCounters(vecs[i].name);
    end

    // Enable drop with a coincident clear on the lag-cycle accept.
    for (int i = 0; i < 3; i++) sendBeat(32'(SEED + i), 0, 0);
    s_axis_tvalid = 1; s_axis_tdata = 32'(SEED + 3); s_axis_tlast = 0;
    for (int n = 0; n < 200 && !s_axis_tready; n++) cycle();
    enable = 0; clear = 1;
    cycle();
    clear = 0;
    chk("en_clr word_count", 64'(word_count), 64'd1);
    chk("en_clr pkt_count", 64'(pkt_count), 64'd0);
    chk("en_clr len_err", 64'(len_err_count), 64'd0);
    chk("en_clr err_flag", {63'd0, err_flag}, 64'd0);
    s_axis_tdata = 32'(SEED + 4);
    for (int n = 0; n < 5; n++) begin
      chk("en_low tready", {63'd0, s_axis_tready}, 64'd0);
      cycle();
    end
    enable = 1;
    for (int i = 4; i < PKT_LEN; i++) sendBeat(32'(SEED + i), (i == PKT_LEN - 1), 0);
    cycle();
    chk("en_clr final pkt_count", 64'(pkt_count), 64'd1);
    chk("en_clr final word_count", 64'(word_count), 64'd5);
    chk("en_clr final pkt_ok", {63'd0, lastOk}, 64'd1);
    checkCounters("en_clr");

    // Reset mid-packet drops the partial packet.
    for (int i = 0; i < 3; i++) sendBeat(32'(SEED + i), 0, 0);
    doReset();
    sendPacket(PKT_LEN, -1, 0);
    cycle();
    chk("post_reset pkt_count", 64'(pkt_count), 64'd1);
    chk("post_reset word_count", 64'(word_count), 64'(PKT_LEN));
    checkCounters("post_reset");

    // Randomized packets: good, short, long, corrupted, with stalls and clears.
    for (int p = 0; p < 150; p++) begin
      int kind, len;
      kind = int'($urandom_range(0, 99));
      if (kind < 70)      len = PKT_LEN;
      else if (kind < 85) len = int'($urandom_range(1, PKT_LEN - 1));
      else                len = int'($urandom_range(PKT_LEN + 1, PKT_LEN + 4));
      for (int i = 0; i < len; i++) begin
        logic [31:0] d;
        d = 32'(SEED + i);
        if ($urandom_range(0, 9) == 0) d = d ^ ($urandom | 32'd1);
        if ($urandom_range(0, 9) == 0) begin
          enable = 0;
          s_axis_tdata = $urandom;
          repeat (int'($urandom_range(1, 3))) cycle();
          enable = 1;
        end
        sendBeat(d, (i == len - 1), ($urandom_range(0, 49) == 0));
      end
      cycle();
      checkCounters("random");
    end

`ifdef AXIS_PATTERN_CHECKER_BP_EN
    // Back-to-back good packets under LFSR backpressure.
    pulseClear();
    totalCycles = 0;
    lowCycles = 0;
    for (int p = 0; p < 100; p++) sendPacket(PKT_LEN, -1, 0);
    cycle();
    chk("bp pkt_count", 64'(pkt_count), 64'd100);
    chk("bp data_err", 64'(data_err_count), 64'd0);
    chk("bp len_err", 64'(len_err_count), 64'd0);
    chk("bp backpressure_30pct", {63'd0, (lowCycles * 100 >= totalCycles * 30)}, 64'd1);
    checkCounters("bp");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_pattern_checker.md
Name: axis_pattern_checker

Overview:
- Downstream AXI4-Stream sink for AXI4_Stream_Data_Source output; replaces the streaming slave BFM in hardware and in the bfm_design bench.
- Accepts packets of fixed length PKT_LEN; the expected word sequence is SEED, SEED+1, … restarting at SEED every packet.
- Checks every data word and packet length; maintains packet, word and error counters plus first-error capture for register readback (AXI-Lite wrapper is out of scope).

Parameters:
- DATA_WIDTH, 32, tdata width in bits; tstrb width is DATA_WIDTH/8.
- PKT_LEN, 8, beats per packet; legal range 2..256.
- SEED, 1, expected value of beat 0 of every packet.
- CNT_WIDTH, 32, width of all counters.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- enable  in  1  level; 0 forces tready low and holds state.
- clear  in  1  synchronous pulse; zeroes counters and sticky flags.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tstrb  in  DATA_WIDTH/8  byte strobe; informational only, never compared.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  source valid.
- s_axis_tready  out  1  registered ready.
- pkt_count  out  CNT_WIDTH  complete packets received, good or bad.
- word_count  out  CNT_WIDTH  accepted beats.
- data_err_count  out  CNT_WIDTH  beats with a data mismatch.
- len_err_count  out  CNT_WIDTH  packets with a short or long length.
- err_flag  out  1  sticky; set on first error of any kind.
- first_err_data  out  DATA_WIDTH  tdata of first mismatching beat.
- first_err_idx  out  8  beat index of first mismatch.
- pkt_done  out  1  one-cycle pulse the cycle after a tlast beat is accepted.
- pkt_ok  out  1  valid with pkt_done; 1 if that packet had no errors.

Behaviour:
- Reset values: all outputs 0, state IDLE, beat_idx 0, expected = SEED.
- Accept occurs when tvalid && tready. tready is registered: next value = enable (AND the backpressure bit when the optional feature is compiled in).
- IDLE: on accept → ACTIVE, with beat 0 handled per the beat rules below.
- ACTIVE: every accepted beat is compared; tdata != expected sets that beat's data error.
  - beat_idx == PKT_LEN-1 with tlast: normal end → IDLE.
  - tlast with beat_idx < PKT_LEN-1: short packet; len error → IDLE.
  - beat_idx == PKT_LEN-1 without tlast: long packet; len error → DRAIN.
- DRAIN: beats are accepted without data checks and word_count still increments; on tlast → IDLE. pkt_done/pkt_ok=0 fire on that beat only.
- Counters and packet boundaries:
  - On packet end: beat_idx=0, expected=SEED, pkt_count+1.
  - Otherwise: beat_idx+1, expected+1. Expected wraps modulo 2^DATA_WIDTH.
- Error counting:
  - data_err_count increments at most once per beat.
  - len_err_count increments at most once per packet.
  - A single beat may raise both a data error and a length error.
- first_err_data/first_err_idx load only on a data mismatch while err_flag=0. A length error sets err_flag but leaves those registers unchanged.
- All counters saturate at all-ones.
- clear coincident with an accept: counters and flags take the cleared value, then the beat's own increment applies, so the result is 0 or 1. FSM progression is unaffected by clear.
- enable low mid-packet: tready drops one cycle later; beat_idx, expected and state are retained. A beat accepted in that one-cycle lag is processed normally.
- Reset mid-packet: immediate return to reset values; a partial packet is not counted.
- PKT_LEN=1 is illegal; the bench asserts this at elaboration.

Optional Feature:
- Macro: AXIS_PATTERN_CHECKER_BP_EN.
- Defined: a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) advances every cycle. tready next = enable && lfsr[0], giving roughly 50% backpressure to exercise source stall handling. The LFSR does not advance during reset.
- Undefined: no LFSR logic; tready next = enable.

Decomposition:
- Package axis_checker_pkg:
  - state enum {IDLE, ACTIVE, DRAIN};
  - LFSR seed and tap constants;
  - saturating-increment function.
- One sub-module, axis_sat_counter (CNT_WIDTH, inc, clr, value), instantiated four times.
- FSM, comparator and capture logic stay in the top level.

Test Plan:
- 8 beats 1..8, tlast on beat 8, enable=1 → pkt_count=1, word_count=8, pkt_done pulse with pkt_ok=1, err_flag=0.
- Same packet with beat 3 = 0xDEAD0000 → data_err_count=1, first_err_data=0xDEAD0000, first_err_idx=3, pkt_ok=0.
- Second packet then corrupts beat 5 → first_err_* unchanged, data_err_count=2.
- Short packet: tlast on beat 5, then a good packet → len_err_count=1, pkt_count=2, second pkt_ok=1.
- Long packet: 10 beats 1..10, tlast on beat 10 → len_err_count=1, data_err_count=0, word_count=10, one pkt_done; next good packet passes.
- enable toggled low for 5 cycles mid-packet, with clear pulsed on the same cycle as a beat accept:
  - counters restart at 0/1 as specified;
  - tready stays low while enable is low;
  - the packet completes with pkt_ok=1.
- With AXIS_PATTERN_CHECKER_BP_EN defined: 100 back-to-back good packets → pkt_count=100, zero errors, tready observed low at least 30% of cycles.
